// File: rtl/pulse_height_detector_if.sv
// Record channel between the pulse height detector and its consumer
// (histogrammer / readout). One record per accepted pulse, valid/ready
// handshake; a record transfers on a clock where out_valid && out_ready.
//
// Parameters: TW = timestamp width, WW = width-field width.
// Signals:
//   out_valid  producer -> consumer  record available
//   out_ready  consumer -> producer  consumer accepts record
//   out_peak   producer -> consumer  peak amplitude, signed 16 bit
//   out_time   producer -> consumer  sample index of first peak occurrence
//   out_width  producer -> consumer  number of above-threshold samples
// Modports: master = record producer (detector), slave = record consumer.
interface pulse_height_detector_if #(
  parameter int TW = 32,
  parameter int WW = 12
);
  logic                 out_valid;
  logic                 out_ready;
  logic signed [15:0]   out_peak;
  logic        [TW-1:0] out_time;
  logic        [WW-1:0] out_width;

  modport master (
    output out_valid, out_peak, out_time, out_width,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_peak, out_time, out_width,
    output out_ready
  );
endinterface

// File: rtl/pulse_height_detector.sv
// Pulse height detector: turns the signed 16-bit shaped-pulse stream into one
// record (peak, timestamp of first peak occurrence, width) per isolated pulse.
// Pulses that pile up during hold-off, or stay above threshold for MAX_WIDTH
// samples, are rejected and counted. Records go out through a one-entry
// valid/ready buffer; a record committed while that buffer is full and not
// draining is dropped and counted.
//
// Optional feature: define PHD_BASELINE_EN to add a 17-bit running baseline
// that tracks the input while idle and is subtracted (saturating) before
// the threshold comparison. Default build: x = in_data, no baseline logic.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     sample strobe; all state advances only on accepted samples
//   in_data      shaped sample, signed
//   threshold    trigger level, signed, compared strictly (x > threshold)
//   rec          record channel (master side)
//   reject_cnt   pile-up + overlong rejections, saturating
//   drop_cnt     records lost to a full output buffer, saturating
module pulse_height_detector #(
  parameter int TW        = 32,
  parameter int HOLDOFF   = 16,
  parameter int MAX_WIDTH = 1024,
  parameter int WW        = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [15:0]       in_data,
  input  logic signed [15:0]       threshold,
  pulse_height_detector_if.master  rec,
  output logic        [15:0]       reject_cnt,
  output logic        [15:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, DISCARD} state_t;

  localparam int HW = $clog2(HOLDOFF + 1);

  state_t               state, state_n;
  logic        [TW-1:0] index;
  logic signed [15:0]   peak;
  logic        [TW-1:0] ptime;
  logic        [WW-1:0] width;
  logic        [HW-1:0] hcnt;

  logic signed [15:0]   x;
  logic                 above;
  logic        [WW:0]   width_inc;
  logic                 overflow;
  logic        [HW-1:0] hcnt_inc;
  logic                 hold_done;

  // Per-sample actions decoded from state and the current sample.
  logic start_evt, extend_evt, reject_evt, commit_evt, hold_enter, hold_step;
  logic load_ok;

`ifdef PHD_BASELINE_EN
  logic signed [16:0] b;
  logic signed [16:0] diff;
  logic               track;

  always_comb begin
    diff = {in_data[15], in_data} - b;
    // Bits 16 and 15 disagree only when the difference leaves 16-bit range.
    if (diff[16] != diff[15])
      x = diff[16] ? 16'sh8000 : 16'sh7fff;
    else
      x = diff[15:0];
  end

  // Baseline follows the input only while no event is being measured.
  assign track = in_valid && (state == IDLE || state == DISCARD);

  always_ff @(posedge clk) begin
    if (rst)
      b <= '0;
    else if (track)
      b <= b + (diff >>> 4);
  end
`else
  assign x = in_data;
`endif

  assign above     = x > threshold;
  assign width_inc = {1'b0, width} + 1'b1;
  assign overflow  = width_inc == (WW+1)'(MAX_WIDTH);
  assign hcnt_inc  = hcnt + 1'b1;
  assign hold_done = hcnt_inc == HW'(HOLDOFF);
  assign load_ok   = !rec.out_valid || rec.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_n
    // unassigned and infers a latch.
    state_n = state;
    if (in_valid) begin
      unique case (state)
        IDLE:    if (above) state_n = ACTIVE;
        ACTIVE:  if (above) begin
                   if (overflow) state_n = DISCARD;
                 end else begin
                   state_n = (HOLDOFF == 1) ? IDLE : HOLD;
                 end
        HOLD:    if (above)          state_n = ACTIVE;
                 else if (hold_done) state_n = IDLE;
        DISCARD: if (!above) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Output/action decode.
  always_comb begin
    start_evt  = 1'b0;
    extend_evt = 1'b0;
    reject_evt = 1'b0;
    commit_evt = 1'b0;
    hold_enter = 1'b0;
    hold_step  = 1'b0;
    if (in_valid) begin
      unique case (state)
        IDLE:    start_evt = above;
        ACTIVE:  if (above) begin
                   extend_evt = !overflow;
                   reject_evt = overflow;
                 end else begin
                   // With HOLDOFF=1 the exit sample itself completes hold-off.
                   commit_evt = (HOLDOFF == 1);
                   hold_enter = (HOLDOFF != 1);
                 end
        HOLD:    if (above) begin
                   // Pile-up: drop the pending event, this sample starts anew.
                   reject_evt = 1'b1;
                   start_evt  = 1'b1;
                 end else begin
                   commit_evt = hold_done;
                   hold_step  = !hold_done;
                 end
        DISCARD: ;
        default: ;
      endcase
    end
  end

  // Event datapath, counters and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      index         <= '0;
      peak          <= '0;
      ptime         <= '0;
      width         <= '0;
      hcnt          <= '0;
      reject_cnt    <= '0;
      drop_cnt      <= '0;
      rec.out_valid <= 1'b0;
      rec.out_peak  <= '0;
      rec.out_time  <= '0;
      rec.out_width <= '0;
    end else begin
      if (in_valid) index <= index + 1'b1;

      if (start_evt) begin
        peak  <= x;
        ptime <= index;
        width <= WW'(1);
      end else if (extend_evt) begin
        width <= width_inc[WW-1:0];
        // Strict compare keeps the earliest sample of an equal-height peak.
        if (x > peak) begin
          peak  <= x;
          ptime <= index;
        end
      end

      if (hold_enter)     hcnt <= HW'(1);
      else if (hold_step) hcnt <= hcnt_inc;

      if (reject_evt && reject_cnt != 16'hffff) reject_cnt <= reject_cnt + 1'b1;

      if (commit_evt && load_ok) begin
        rec.out_valid <= 1'b1;
        rec.out_peak  <= peak;
        rec.out_time  <= ptime;
        rec.out_width <= width;
      end else if (rec.out_valid && rec.out_ready) begin
        rec.out_valid <= 1'b0;
      end

      if (commit_evt && !load_ok && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_height_detector.sv
// Directed testbench for pulse_height_detector (HOLDOFF=4, MAX_WIDTH=8).
// Scenarios: reset state, single pulse, pile-up, overlong, backpressure
// (drop and same-cycle replace), input gaps, reset during an event, and the
// baseline feature when PHD_BASELINE_EN is defined.
module tb_pulse_height_detector;

  localparam int TW = 32;
  localparam int WW = 12;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic signed [15:0] threshold;
  logic        [15:0] reject_cnt;
  logic        [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  int single_p[10] = '{0, 50, 150, 300, 200, 90, 0, 0, 0, 0};
  int pileup_p[10] = '{0, 0, 150, 50, 200, 80, 0, 0, 0, 0};
  int clean_a[6]   = '{0, 300, 0, 0, 0, 0};
  int clean_b[6]   = '{0, 250, 0, 0, 0, 0};
  int clean_c[6]   = '{0, 400, 0, 0, 0, 0};

  pulse_height_detector_if #(.TW(TW), .WW(WW)) rec ();

  pulse_height_detector #(
    .TW(TW), .HOLDOFF(4), .MAX_WIDTH(8), .WW(WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .threshold  (threshold),
    .rec        (rec.master),
    .reject_cnt (reject_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one input for one clock; returns 1 time unit after the edge.
  task automatic step(input logic v, input int d);
    in_valid = v;
    in_data  = 16'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_record(input string tag, input int pk, input int tm, input int wd);
    check({tag, ".valid"}, {31'd0, rec.out_valid}, 32'd1);
    check({tag, ".peak"},  {16'd0, rec.out_peak},  32'(pk));
    check({tag, ".time"},  rec.out_time,           32'(tm));
    check({tag, ".width"}, {20'd0, rec.out_width}, 32'(wd));
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    threshold     = 16'sd100;
    rec.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst.valid",  {31'd0, rec.out_valid}, 32'd0);
    check("rst.peak",   {16'd0, rec.out_peak},  32'd0);
    check("rst.time",   rec.out_time,           32'd0);
    check("rst.width",  {20'd0, rec.out_width}, 32'd0);
    check("rst.reject", {16'd0, reject_cnt},    32'd0);
    check("rst.drop",   {16'd0, drop_cnt},      32'd0);

    // Single pulse: commit on idx8, record visible right after that edge
    for (int i = 0; i < 8; i++) step(1'b1, single_p[i]);
    check("single.pre_valid", {31'd0, rec.out_valid}, 32'd0);
    step(1'b1, single_p[8]);
    check_record("single", 300, 3, 3);
    check("single.reject", {16'd0, reject_cnt}, 32'd0);
    step(1'b1, single_p[9]);
    check("single.drained", {31'd0, rec.out_valid}, 32'd0);

    // Pile-up: first event rejected, second reported
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, pileup_p[i]);
    check_record("pileup", 200, 4, 1);
    check("pileup.reject", {16'd0, reject_cnt}, 32'd1);
    step(1'b1, pileup_p[9]);

    // Overlong: reject exactly when width reaches MAX_WIDTH, then DISCARD
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 500);
    check("overlong.reject_w7", {16'd0, reject_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 500);
    check("overlong.reject", {16'd0, reject_cnt}, 32'd1);
    check("overlong.no_rec", {31'd0, rec.out_valid}, 32'd0);
    step(1'b1, 0);
    for (int i = 0; i < 6; i++) step(1'b1, clean_c[i]);
    check_record("overlong.next", 400, 12, 1);
    check("overlong.reject_end", {16'd0, reject_cnt}, 32'd1);

    // Backpressure: second commit dropped, first record held
    do_reset();
    rec.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, clean_a[i]);
    check_record("bp.first", 300, 1, 1);
    for (int i = 0; i < 5; i++) step(1'b1, clean_b[i]);
    check("bp.hold_peak", {16'd0, rec.out_peak}, 32'd300);
    step(1'b1, clean_b[5]);
    check_record("bp.held", 300, 1, 1);
    check("bp.drop", {16'd0, drop_cnt}, 32'd1);
    rec.out_ready = 1'b1;
    step(1'b0, 0);
    check("bp.drained", {31'd0, rec.out_valid}, 32'd0);

    // Backpressure: ready at the second commit replaces the first record
    do_reset();
    rec.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, clean_a[i]);
    for (int i = 0; i < 5; i++) step(1'b1, clean_b[i]);
    rec.out_ready = 1'b1;
    step(1'b1, clean_b[5]);
    check_record("bp.replace", 250, 7, 1);
    check("bp.replace_drop", {16'd0, drop_cnt}, 32'd0);
    step(1'b0, 0);

    // Gaps: idle cycles carry an above-threshold value that must be ignored
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, single_p[i]);
      if (i < 8) step(1'b0, 1000);
    end
    check_record("gaps", 300, 3, 3);
    step(1'b0, 1000);
    check("gaps.drained", {31'd0, rec.out_valid}, 32'd0);

    // Reset during ACTIVE aborts the event and restarts the index
    do_reset();
    step(1'b1, 0);
    step(1'b1, 150);
    step(1'b1, 300);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd300;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rstact.valid", {31'd0, rec.out_valid}, 32'd0);
    check("rstact.peak",  {16'd0, rec.out_peak},  32'd0);
    check("rstact.time",  rec.out_time,           32'd0);
    check("rstact.width", {20'd0, rec.out_width}, 32'd0);
    step(1'b1, 200);
    for (int i = 0; i < 4; i++) step(1'b1, 0);
    check_record("rstact.next", 200, 0, 1);
    step(1'b0, 0);

`ifdef PHD_BASELINE_EN
    // Baseline convergence, then a corrected pulse
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1000);
    check("bl.no_rec", {31'd0, rec.out_valid}, 32'd0);
    check("bl.converged", {31'd0, (dut.b >= 17'sd984 && dut.b <= 17'sd1000)}, 32'd1);
    step(1'b1, 1400);
    for (int i = 0; i < 4; i++) step(1'b1, 1000);
    check("bl.valid", {31'd0, rec.out_valid}, 32'd1);
    check("bl.peak_range", {31'd0, (rec.out_peak >= 16'sd384 && rec.out_peak <= 16'sd416)}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
